// File: rtl/i2c_bus_monitor.sv
// Passive I2C bus monitor: synchronises and de-glitches SCL/SDA, detects
// START/STOP, and reports address/data bytes and ACK bits as single-cycle pulses.
module i2c_bus_monitor #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3,
  parameter int unsigned CNT_W       = 8,
  parameter logic [6:0]  OWN_ADDR    = 7'h50
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             start_det,
  output logic             rstart_det,
  output logic             stop_det,
  output logic             byte_valid,
  output logic [7:0]       byte_data,
  output logic             byte_is_addr,
  output logic             ack_valid,
  output logic             ack_bit,
  output logic             addr_match,
  output logic             rw,
  output logic [CNT_W-1:0] byte_count,
  output logic             busy,
  output logic             bus_error,
  output logic [2:0]       state
);

  localparam int unsigned FCNT_W = 4;
  localparam int unsigned BCNT_W = 3;
  localparam int unsigned LINES  = 2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR      = 3'd1,
    S_ADDR_ACK  = 3'd2,
    S_DATA      = 3'd3,
    S_DATA_ACK  = 3'd4,
    S_WAIT_STOP = 3'd5
  } state_t;

  // Line index 0 is SCL, index 1 is SDA.
  logic [LINES-1:0]       raw;
  logic [SYNC_STAGES-1:0] sync_q [LINES];
  logic [FCNT_W-1:0]      fcnt_q [LINES];
  logic [LINES-1:0]       filt_q;
  logic [LINES-1:0]       filt_d_q;

  assign raw = {sda_in, scl_in};

  // Synchroniser chain plus persistence filter per line; both idle high.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(LINES); i++) begin
      if (reset) begin
        sync_q[i] <= '1;
        fcnt_q[i] <= '0;
        filt_q[i] <= 1'b1;
      end else begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
        if (sync_q[i][SYNC_STAGES-1] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FCNT_W'(FILTER_LEN - 1)) begin
          filt_q[i] <= sync_q[i][SYNC_STAGES-1];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + FCNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) filt_d_q <= '1;
    else       filt_d_q <= filt_q;
  end

  logic scl_f, sda_f, scl_p, sda_p;
  logic start_c, stop_c, scl_rise_c;

  assign scl_f = filt_q[0];
  assign sda_f = filt_q[1];
  assign scl_p = filt_d_q[0];
  assign sda_p = filt_d_q[1];

  // SCL must be stable high across the SDA transition, so a simultaneous
  // SCL change suppresses START/STOP.
  assign start_c    = scl_p & scl_f & sda_p & ~sda_f;
  assign stop_c     = scl_p & scl_f & ~sda_p & sda_f;
  assign scl_rise_c = ~scl_p & scl_f;

  state_t            st_q, st_n;
  logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_n;
  logic [6:0]        shreg_q, shreg_n;
  logic [7:0]        byte_c;
  logic [CNT_W-1:0]  byte_count_n;
  logic              busy_n, addr_match_n, rw_n, byte_is_addr_n, ack_bit_n;
  logic [7:0]        byte_data_n;
  logic              start_n, rstart_n, stop_n, byte_valid_n, ack_valid_n, bus_error_n;

  assign byte_c = {shreg_q, sda_f};
  assign state  = st_q;

  // Next-state and output decode; START/STOP outrank a coincident SCL rise.
  always_comb begin
    st_n           = st_q;
    bit_cnt_n      = bit_cnt_q;
    shreg_n        = shreg_q;
    byte_count_n   = byte_count;
    busy_n         = busy;
    addr_match_n   = addr_match;
    rw_n           = rw;
    byte_data_n    = byte_data;
    byte_is_addr_n = byte_is_addr;
    ack_bit_n      = ack_bit;
    start_n        = 1'b0;
    rstart_n       = 1'b0;
    stop_n         = 1'b0;
    byte_valid_n   = 1'b0;
    ack_valid_n    = 1'b0;
    bus_error_n    = 1'b0;

    if (start_c) begin
      start_n      = ~busy;
      rstart_n     = busy;
      busy_n       = 1'b1;
      st_n         = S_ADDR;
      bit_cnt_n    = '0;
      byte_count_n = '0;
      addr_match_n = 1'b0;
      rw_n         = 1'b0;
    end else if (stop_c) begin
      stop_n       = 1'b1;
      bus_error_n  = ((st_q == S_ADDR) || (st_q == S_DATA)) && (bit_cnt_q != '0);
      st_n         = S_IDLE;
      busy_n       = 1'b0;
      addr_match_n = 1'b0;
      rw_n         = 1'b0;
      bit_cnt_n    = '0;
    end else if (scl_rise_c) begin
      unique case (st_q)
        S_ADDR, S_DATA: begin
          shreg_n = {shreg_q[5:0], sda_f};
          if (bit_cnt_q == BCNT_W'(7)) begin
            bit_cnt_n    = '0;
            byte_valid_n = 1'b1;
            byte_data_n  = byte_c;
            if (byte_count != {CNT_W{1'b1}}) byte_count_n = byte_count + CNT_W'(1);
            if (st_q == S_ADDR) begin
              byte_is_addr_n = 1'b1;
              addr_match_n   = (shreg_q == OWN_ADDR);
              rw_n           = sda_f;
              st_n           = S_ADDR_ACK;
            end else begin
              byte_is_addr_n = 1'b0;
              st_n           = S_DATA_ACK;
            end
          end else begin
            bit_cnt_n = bit_cnt_q + BCNT_W'(1);
          end
        end
        S_ADDR_ACK, S_DATA_ACK: begin
          ack_bit_n   = sda_f;
          ack_valid_n = 1'b1;
          st_n        = sda_f ? S_WAIT_STOP : S_DATA;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q         <= S_IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      byte_count   <= '0;
      busy         <= 1'b0;
      addr_match   <= 1'b0;
      rw           <= 1'b0;
      byte_data    <= '0;
      byte_is_addr <= 1'b0;
      ack_bit      <= 1'b0;
      start_det    <= 1'b0;
      rstart_det   <= 1'b0;
      stop_det     <= 1'b0;
      byte_valid   <= 1'b0;
      ack_valid    <= 1'b0;
      bus_error    <= 1'b0;
    end else begin
      st_q         <= st_n;
      bit_cnt_q    <= bit_cnt_n;
      shreg_q      <= shreg_n;
      byte_count   <= byte_count_n;
      busy         <= busy_n;
      addr_match   <= addr_match_n;
      rw           <= rw_n;
      byte_data    <= byte_data_n;
      byte_is_addr <= byte_is_addr_n;
      ack_bit      <= ack_bit_n;
      start_det    <= start_n;
      rstart_det   <= rstart_n;
      stop_det     <= stop_n;
      byte_valid   <= byte_valid_n;
      ack_valid    <= ack_valid_n;
      bus_error    <= bus_error_n;
    end
  end

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Directed bench for i2c_bus_monitor: drives bit-banged I2C traffic on the raw
// pins and checks the reported events against hand-computed values.
module tb_i2c_bus_monitor;
  localparam int H = 10;

  logic       clk = 1'b0;
  logic       reset, scl_in, sda_in;
  logic       start_det, rstart_det, stop_det, byte_valid, byte_is_addr;
  logic       ack_valid, ack_bit, addr_match, rw, busy, bus_error;
  logic [7:0] byte_data, byte_count;
  logic [2:0] state;
  logic [29:0] all_o;

  i2c_bus_monitor dut (
    .clk(clk), .reset(reset), .scl_in(scl_in), .sda_in(sda_in),
    .start_det(start_det), .rstart_det(rstart_det), .stop_det(stop_det),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_is_addr(byte_is_addr),
    .ack_valid(ack_valid), .ack_bit(ack_bit), .addr_match(addr_match), .rw(rw),
    .byte_count(byte_count), .busy(busy), .bus_error(bus_error), .state(state)
  );

  always #5 clk = ~clk;

  assign all_o = {start_det, rstart_det, stop_det, byte_valid, byte_data, byte_is_addr,
                  ack_valid, ack_bit, addr_match, rw, byte_count, busy, bus_error, state};

  int total = 0;
  int bad   = 0;

  // Event recorder: counts pulses and captures {is_addr, addr_match, rw, byte}.
  int          n_start = 0, n_rstart = 0, n_stop = 0, n_byte = 0, n_ack = 0;
  int          n_err = 0, n_stop_err = 0;
  logic [10:0] seen [64];
  logic        last_ack = 1'b0;

  always @(negedge clk) begin
    if (start_det)  n_start  <= n_start + 1;
    if (rstart_det) n_rstart <= n_rstart + 1;
    if (stop_det)   n_stop   <= n_stop + 1;
    if (bus_error)  n_err    <= n_err + 1;
    if (stop_det && bus_error) n_stop_err <= n_stop_err + 1;
    if (ack_valid) begin
      n_ack    <= n_ack + 1;
      last_ack <= ack_bit;
    end
    if (byte_valid) begin
      seen[n_byte % 64] <= {byte_is_addr, addr_match, rw, byte_data};
      n_byte <= n_byte + 1;
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    scl_in = 1'b1; sda_in = 1'b1; hold(H);
    sda_in = 1'b0; hold(H);
    scl_in = 1'b0; hold(H);
  endtask

  task automatic i2c_rstart();
    sda_in = 1'b1; hold(H);
    scl_in = 1'b1; hold(H);
    sda_in = 1'b0; hold(H);
    scl_in = 1'b0; hold(H);
  endtask

  task automatic i2c_stop();
    sda_in = 1'b0; hold(H);
    scl_in = 1'b1; hold(H);
    sda_in = 1'b1; hold(H);
  endtask

  task automatic send_bit(input logic b);
    sda_in = b;    hold(H);
    scl_in = 1'b1; hold(H);
    scl_in = 1'b0; hold(H);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic test_reset();
    reset = 1'b1; scl_in = 1'b1; sda_in = 1'b1;
    hold(3);
    total++; if (all_o !== 30'd0) begin bad++; $display("FAIL reset_outputs: got %h want 0", all_o); end
    total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
    reset = 1'b0;
    hold(H);
    total++; if (all_o !== 30'd0) begin bad++; $display("FAIL idle_after_reset: got %h want 0", all_o); end
  endtask

  task automatic test_write_frame();
    int s0, r0, b0, a0, p0;
    s0 = n_start; r0 = n_rstart; b0 = n_byte; a0 = n_ack; p0 = n_stop;
    i2c_start();
    total++; if (n_start !== s0 + 1) begin bad++; $display("FAIL wf_start: got %0d want %0d", n_start, s0 + 1); end
    total++; if (n_rstart !== r0) begin bad++; $display("FAIL wf_no_rstart: got %0d want %0d", n_rstart, r0); end
    total++; if (busy !== 1'b1 || state !== 3'd1) begin bad++; $display("FAIL wf_busy_state: got %b/%0d want 1/1", busy, state); end
    send_byte(8'hA0);
    total++; if (n_byte !== b0 + 1) begin bad++; $display("FAIL wf_addr_count: got %0d want %0d", n_byte, b0 + 1); end
    total++; if (seen[b0 % 64] !== {3'b110, 8'hA0}) begin bad++; $display("FAIL wf_addr_byte: got %h want %h", seen[b0 % 64], {3'b110, 8'hA0}); end
    total++; if (state !== 3'd2 || byte_count !== 8'd1) begin bad++; $display("FAIL wf_addr_ack_state: got %0d/%0d want 2/1", state, byte_count); end
    send_bit(1'b0);
    total++; if (n_ack !== a0 + 1 || last_ack !== 1'b0) begin bad++; $display("FAIL wf_addr_ack: got %0d/%b want %0d/0", n_ack, last_ack, a0 + 1); end
    total++; if (state !== 3'd3) begin bad++; $display("FAIL wf_data_state: got %0d want 3", state); end
    send_byte(8'h3C);
    total++; if (seen[(b0 + 1) % 64] !== {3'b010, 8'h3C}) begin bad++; $display("FAIL wf_data_byte: got %h want %h", seen[(b0 + 1) % 64], {3'b010, 8'h3C}); end
    total++; if (state !== 3'd4) begin bad++; $display("FAIL wf_data_ack_state: got %0d want 4", state); end
    send_bit(1'b0);
    total++; if (byte_count !== 8'd2 || last_ack !== 1'b0) begin bad++; $display("FAIL wf_byte_count: got %0d/%b want 2/0", byte_count, last_ack); end
    i2c_stop();
    total++; if (n_stop !== p0 + 1) begin bad++; $display("FAIL wf_stop: got %0d want %0d", n_stop, p0 + 1); end
    total++; if (busy !== 1'b0 || state !== 3'd0 || addr_match !== 1'b0) begin bad++; $display("FAIL wf_after_stop: got %b/%0d/%b want 0/0/0", busy, state, addr_match); end
  endtask

  task automatic test_nack_wait();
    int s0, b0, p0, e0;
    s0 = n_start; p0 = n_stop; e0 = n_err;
    i2c_start();
    total++; if (n_start !== s0 + 1) begin bad++; $display("FAIL nk_start: got %0d want %0d", n_start, s0 + 1); end
    b0 = n_byte;
    send_byte(8'hA3);
    total++; if (seen[b0 % 64] !== {3'b101, 8'hA3}) begin bad++; $display("FAIL nk_addr_byte: got %h want %h", seen[b0 % 64], {3'b101, 8'hA3}); end
    total++; if (addr_match !== 1'b0 || rw !== 1'b1) begin bad++; $display("FAIL nk_match_rw: got %b/%b want 0/1", addr_match, rw); end
    send_bit(1'b1);
    total++; if (last_ack !== 1'b1 || state !== 3'd5) begin bad++; $display("FAIL nk_nack: got %b/%0d want 1/5", last_ack, state); end
    send_byte(8'h55);
    total++; if (n_byte !== b0 + 1 || state !== 3'd5) begin bad++; $display("FAIL nk_ignored: got %0d/%0d want %0d/5", n_byte, state, b0 + 1); end
    i2c_stop();
    total++; if (n_stop !== p0 + 1 || n_err !== e0 || state !== 3'd0) begin bad++; $display("FAIL nk_stop: got %0d/%0d/%0d want %0d/%0d/0", n_stop, n_err, state, p0 + 1, e0); end
  endtask

  task automatic test_rstart();
    int s0, r0;
    s0 = n_start; r0 = n_rstart;
    i2c_start();
    send_byte(8'hA0);
    send_bit(1'b0);
    total++; if (byte_count !== 8'd1) begin bad++; $display("FAIL rs_count_before: got %0d want 1", byte_count); end
    i2c_rstart();
    total++; if (n_rstart !== r0 + 1 || n_start !== s0 + 1) begin bad++; $display("FAIL rs_pulses: got %0d/%0d want %0d/%0d", n_rstart, n_start, r0 + 1, s0 + 1); end
    total++; if (byte_count !== 8'd0 || state !== 3'd1 || busy !== 1'b1) begin bad++; $display("FAIL rs_restart: got %0d/%0d/%b want 0/1/1", byte_count, state, busy); end
    send_byte(8'hA1);
    total++; if (byte_count !== 8'd1 || rw !== 1'b1 || addr_match !== 1'b1) begin bad++; $display("FAIL rs_read_addr: got %0d/%b/%b want 1/1/1", byte_count, rw, addr_match); end
    send_bit(1'b0);
    i2c_stop();
  endtask

  task automatic test_stop_error();
    int q0;
    q0 = n_stop_err;
    i2c_start();
    send_byte(8'hA0);
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    total++; if (state !== 3'd3) begin bad++; $display("FAIL se_mid_byte: got %0d want 3", state); end
    i2c_stop();
    total++; if (n_stop_err !== q0 + 1) begin bad++; $display("FAIL se_stop_and_error: got %0d want %0d", n_stop_err, q0 + 1); end
    total++; if (state !== 3'd0 || busy !== 1'b0) begin bad++; $display("FAIL se_idle: got %0d/%b want 0/0", state, busy); end
  endtask

  task automatic test_glitch();
    int s0, p0, first;
    scl_in = 1'b1; sda_in = 1'b1; hold(H);
    s0 = n_start; p0 = n_stop;
    sda_in = 1'b0; hold(2);
    sda_in = 1'b1; hold(15);
    total++; if (n_start !== s0 || n_stop !== p0) begin bad++; $display("FAIL gl_glitch: got %0d/%0d want %0d/%0d", n_start, n_stop, s0, p0); end
    first = 0;
    sda_in = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 3) sda_in = 1'b1;
      if (start_det === 1'b1 && first == 0) first = k;
    end
    total++; if (first !== 6) begin bad++; $display("FAIL gl_latency: got %0d want 6", first); end
    hold(H);
    total++; if (n_start !== s0 + 1 || n_stop !== p0 + 1) begin bad++; $display("FAIL gl_events: got %0d/%0d want %0d/%0d", n_start, n_stop, s0 + 1, p0 + 1); end
  endtask

  task automatic test_reset_midframe();
    int b0, e0, s0;
    i2c_start();
    send_byte(8'hA0);
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    total++; if (state !== 3'd3) begin bad++; $display("FAIL rm_mid_byte: got %0d want 3", state); end
    b0 = n_byte; e0 = n_err; s0 = n_start;
    reset = 1'b1;
    @(negedge clk);
    total++; if (all_o !== 30'd0) begin bad++; $display("FAIL rm_outputs: got %h want 0", all_o); end
    reset = 1'b0;
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    send_bit(1'b0);
    send_byte(8'hFF);
    total++; if (n_byte !== b0 || state !== 3'd0 || n_start !== s0) begin bad++; $display("FAIL rm_ignored: got %0d/%0d/%0d want %0d/0/%0d", n_byte, state, n_start, b0, s0); end
    total++; if (n_err !== e0) begin bad++; $display("FAIL rm_no_error: got %0d want %0d", n_err, e0); end
    i2c_start();
    send_byte(8'hA1);
    total++; if (n_byte !== b0 + 1 || seen[b0 % 64] !== {3'b111, 8'hA1}) begin bad++; $display("FAIL rm_new_frame: got %0d/%h want %0d/%h", n_byte, seen[b0 % 64], b0 + 1, {3'b111, 8'hA1}); end
    send_bit(1'b1);
    i2c_stop();
  endtask

  initial begin
    test_reset();
    test_write_frame();
    test_nack_wait();
    test_rstart();
    test_stop_error();
    test_glitch();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/i2c_bus_monitor.md
I2C_BUS_MONITOR -- requirements
Module: i2c_bus_monitor

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchroniser flops per input, legal range 2..4.
REQ-002 Parameter FILTER_LEN, default 3: consecutive equal samples needed before a filtered line changes, legal range 1..15.
REQ-003 Parameter CNT_W, default 8: width of the frame byte counter.
REQ-004 Parameter OWN_ADDR, default 7'h50: 7-bit address compared against the address byte.
REQ-005 clk  input  1  system clock; every output is registered on its rising edge.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 scl_in, sda_in  input  1 each  raw asynchronous bus lines.
REQ-008 start_det, rstart_det, stop_det  output  1 each  one-cycle pulses for START, repeated START and STOP.
REQ-009 byte_valid  output  1  one-cycle pulse; byte_data[7:0] and byte_is_addr are valid with it.
REQ-010 ack_valid  output  1  one-cycle pulse; ack_bit (0 = ACK, 1 = NACK) is valid with it.
REQ-011 addr_match, rw  output  1 each  held from the address byte until the next START or STOP.
REQ-012 byte_count  output  CNT_W  number of bytes completed in the current frame, address byte included.
REQ-013 busy, bus_error  output  1 each  busy: frame in progress; bus_error: one-cycle pulse.
REQ-014 state  output  3  FSM state encoding: IDLE=0, ADDR=1, ADDR_ACK=2, DATA=3, DATA_ACK=4, WAIT_STOP=5.

Function
REQ-015 Each raw input shall pass through SYNC_STAGES flops, then a filter.
REQ-016 A filtered line shall take a new value only after the synchronised value has differed from it for FILTER_LEN consecutive cycles.
REQ-017 The filters shall reset to 1 (idle bus).
REQ-018 Event latency: a pulse appears SYNC_STAGES+FILTER_LEN+1 cycles after the raw pin edge, with the raw level held stable.
REQ-019 START: filtered sda falls while filtered scl is 1 in both the previous and the current cycle.
REQ-020 STOP: filtered sda rises while filtered scl is 1 in both the previous and the current cycle.
REQ-021 When filtered scl and filtered sda change in the same cycle, no START or STOP shall be detected; a scl rise in that cycle samples the new sda value.
REQ-022 START with busy=0: pulse start_det.
REQ-023 START with busy=1: pulse rstart_det instead of start_det.
REQ-024 Any START from any state: set busy, go to ADDR, clear the bit counter and byte_count, clear addr_match and rw.
REQ-025 STOP from any state: pulse stop_det, go to IDLE, clear busy, addr_match and rw.
REQ-026 STOP from ADDR or DATA with bit counter not 0: also pulse bus_error.
REQ-027 ADDR/DATA: on each filtered scl rising edge, shift sda in MSB first.
REQ-028 On the 8th bit: pulse byte_valid with the byte and increment byte_count, saturating at 2^CNT_W-1.
REQ-029 After the 8th bit, ADDR shall go to ADDR_ACK and DATA shall go to DATA_ACK.
REQ-030 ADDR byte: byte_is_addr=1, addr_match=(byte[7:1]==OWN_ADDR), rw=byte[0]; all three update in the same cycle as byte_valid.
REQ-031 ADDR_ACK/DATA_ACK: on the next scl rise, sample sda into ack_bit and pulse ack_valid.
REQ-032 After that sample: ACK goes to DATA, NACK goes to WAIT_STOP.
REQ-033 WAIT_STOP: ignore scl edges; leave only on START or STOP.
REQ-034 IDLE: ignore scl edges and sda changes other than START.
REQ-035 A scl falling edge shall have no effect other than filter and edge tracking.
REQ-036 When a START or STOP coincides with a scl rise in the same cycle, the START or STOP takes priority and no bit is shifted.

Reset
REQ-037 While reset is high at a clk edge: synchronisers and filters go to 1, state=IDLE.
REQ-038 While reset is high at a clk edge: bit counter and byte_count go to 0, and every output is 0.
REQ-039 Reset asserted mid-frame shall abandon the frame with no bus_error pulse.
REQ-040 After reset, a START is needed before any byte is reported.

Verification
REQ-041 START, address 0xA0 (0x50 write), ACK, data 0x3C, ACK, STOP -> start_det; byte 0xA0 with byte_is_addr=1, addr_match=1, rw=0; ack_bit=0; byte 0x3C; byte_count=2; stop_det; busy=0.
REQ-042 Address 0xA3, then NACK -> addr_match=0, rw=1, state=WAIT_STOP; further scl pulses produce no byte_valid until STOP.
REQ-043 START, address byte, ACK, repeated START, 0xA1 -> rstart_det=1, start_det=0, byte_count restarts at 1, rw=1.
REQ-044 STOP after 3 data bits -> stop_det and bus_error in the same cycle; state=IDLE.
REQ-045 A 2-cycle sda glitch with FILTER_LEN=3 while scl is high -> no start_det or stop_det; a 3-cycle low on sda -> start_det exactly 6 cycles after the pin edge.
REQ-046 Reset pulse in the middle of a data byte -> all outputs 0, state=IDLE next cycle; the following bits are ignored until a new START.
